// File: rtl/text_pkg.sv
// Shared constants, control codes and sweep/FSM state encoding for the text writer.
package text_pkg;

   // Default screen geometry: 640x480 pixels with 8x8 glyph cells.
   localparam int COLS   = 80;
   localparam int ROWS   = 60;
   localparam int ADDR_W = 13;

   // Control codes recognised in the byte stream.
   localparam logic [7:0] CH_BS  = 8'h08;
   localparam logic [7:0] CH_LF  = 8'h0A;
   localparam logic [7:0] CH_FF  = 8'h0C;
   localparam logic [7:0] CH_CR  = 8'h0D;
   localparam logic [7:0] CH_DEL = 8'h7F;
   localparam logic [7:0] BLANK  = 8'h20;

   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      CLR_LINE   = 2'd1,
      CLR_SCREEN = 2'd2
   } state_t;

   // Glyph codes: everything from space upward except DEL (high half included).
   function automatic logic is_printable(input logic [7:0] code);
      return (code >= 8'h20) && (code != CH_DEL);
   endfunction

endpackage

// File: rtl/text_writer_cell_sweep.sv
// Generates a run of consecutive RAM addresses, one per cycle, for clearing cells.
// Comes out of reset already running a full-screen sweep from address 0.
module cell_sweep #(
   parameter int ADDR_W     = text_pkg::ADDR_W,
   parameter int CNT_W      = ADDR_W + 1,
   parameter int INIT_COUNT = text_pkg::COLS * text_pkg::ROWS
) (
   input  logic              px_clk,
   input  logic              rst,
   input  logic              start,
   input  logic [ADDR_W-1:0] base,
   input  logic [CNT_W-1:0]  count,   // number of cells, must be >= 1
   output logic [ADDR_W-1:0] addr,
   output logic              active,
   output logic              done
);

   logic              active_reg;
   logic [ADDR_W-1:0] addr_reg;
   logic [CNT_W-1:0]  remain_reg;

   // Address walks upward while the remaining-cell count walks down to one.
   always_ff @(posedge px_clk or posedge rst) begin
      if (rst) begin
         active_reg <= 1'b1;
         addr_reg   <= '0;
         remain_reg <= CNT_W'(INIT_COUNT);
      end else if (start) begin
         active_reg <= 1'b1;
         addr_reg   <= base;
         remain_reg <= count;
      end else if (active_reg) begin
         if (done) begin
            active_reg <= 1'b0;
         end else begin
            addr_reg   <= addr_reg + ADDR_W'(1);
            remain_reg <= remain_reg - CNT_W'(1);
         end
      end
   end

   assign addr   = addr_reg;
   assign active = active_reg;
   assign done   = active_reg && (remain_reg == CNT_W'(1));

endmodule

// File: rtl/text_writer.sv
// Terminal-style byte stream to character RAM writer with cursor, wrap and clears.
module text_writer #(
   parameter int         COLS   = text_pkg::COLS,
   parameter int         ROWS   = text_pkg::ROWS,
   parameter int         ADDR_W = text_pkg::ADDR_W,
   parameter logic [7:0] BLANK  = text_pkg::BLANK
) (
   input  logic              px_clk,
   input  logic              rst,
   input  logic              in_valid,
   input  logic [7:0]        in_data,
   output logic              in_ready,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [7:0]        wr_data,
   output logic [6:0]        cur_col,
   output logic [5:0]        cur_row,
   output logic              busy
);

   import text_pkg::*;

   localparam int CNT_W    = ADDR_W + 1;
   localparam int LAST_COL = COLS - 1;
   localparam int LAST_ROW = ROWS - 1;

   state_t            state_reg, state_next;
   logic [6:0]        col_reg, col_next;
   logic [5:0]        row_reg, row_next;
   logic [ADDR_W-1:0] row_base_reg, row_base_next;
   logic              wr_en_reg, wr_en_next;
   logic [ADDR_W-1:0] wr_addr_reg, wr_addr_next;
   logic [7:0]        wr_data_reg, wr_data_next;

   logic [5:0]        adv_row;
   logic [ADDR_W-1:0] adv_base;

   logic              sweep_start;
   logic [ADDR_W-1:0] sweep_base;
   logic [CNT_W-1:0]  sweep_count;
   logic [ADDR_W-1:0] sweep_addr;
   logic              sweep_active;
   logic              sweep_done;

   cell_sweep #(
      .ADDR_W     (ADDR_W),
      .CNT_W      (CNT_W),
      .INIT_COUNT (COLS * ROWS)
   ) u_sweep (
      .px_clk (px_clk),
      .rst    (rst),
      .start  (sweep_start),
      .base   (sweep_base),
      .count  (sweep_count),
      .addr   (sweep_addr),
      .active (sweep_active),
      .done   (sweep_done)
   );

   // State, cursor and registered RAM write port.
   always_ff @(posedge px_clk or posedge rst) begin
      if (rst) begin
         state_reg    <= CLR_SCREEN;
         col_reg      <= '0;
         row_reg      <= '0;
         row_base_reg <= '0;
         wr_en_reg    <= 1'b0;
         wr_addr_reg  <= '0;
         wr_data_reg  <= BLANK;
      end else begin
         state_reg    <= state_next;
         col_reg      <= col_next;
         row_reg      <= row_next;
         row_base_reg <= row_base_next;
         wr_en_reg    <= wr_en_next;
         wr_addr_reg  <= wr_addr_next;
         wr_data_reg  <= wr_data_next;
      end
   end

   // Byte interpretation in IDLE; sweep forwarding in the clear states.
   always_comb begin
      state_next    = state_reg;
      col_next      = col_reg;
      row_next      = row_reg;
      row_base_next = row_base_reg;
      wr_en_next    = 1'b0;
      wr_addr_next  = wr_addr_reg;
      wr_data_next  = wr_data_reg;
      sweep_start   = 1'b0;
      sweep_base    = '0;
      sweep_count   = CNT_W'(COLS);

      // Next row wraps to the top rather than scrolling.
      if (row_reg == 6'(LAST_ROW)) begin
         adv_row  = '0;
         adv_base = '0;
      end else begin
         adv_row  = row_reg + 6'd1;
         adv_base = row_base_reg + ADDR_W'(COLS);
      end

      case (state_reg)
         IDLE: begin
            if (in_valid) begin
               if (is_printable(in_data)) begin
                  wr_en_next   = 1'b1;
                  wr_addr_next = row_base_reg + ADDR_W'(col_reg);
                  wr_data_next = in_data;
                  if (col_reg == 7'(LAST_COL)) begin
                     col_next      = '0;
                     row_next      = adv_row;
                     row_base_next = adv_base;
                     sweep_start   = 1'b1;
                     sweep_base    = adv_base;
                     state_next    = CLR_LINE;
                  end else begin
                     col_next = col_reg + 7'd1;
                  end
               end else begin
                  case (in_data)
                     CH_CR: col_next = '0;
                     CH_LF: begin
                        row_next      = adv_row;
                        row_base_next = adv_base;
                        sweep_start   = 1'b1;
                        sweep_base    = adv_base;
                        state_next    = CLR_LINE;
                     end
                     CH_BS: begin
                        if (col_reg != 7'd0) begin
                           col_next     = col_reg - 7'd1;
                           wr_en_next   = 1'b1;
                           wr_addr_next = row_base_reg + ADDR_W'(col_reg - 7'd1);
                           wr_data_next = BLANK;
                        end
                     end
                     CH_FF: begin
                        col_next      = '0;
                        row_next      = '0;
                        row_base_next = '0;
                        sweep_start   = 1'b1;
                        sweep_base    = '0;
                        sweep_count   = CNT_W'(COLS * ROWS);
                        state_next    = CLR_SCREEN;
                     end
                     default: ;
                  endcase
               end
            end
         end
         CLR_LINE, CLR_SCREEN: begin
            wr_en_next   = sweep_active;
            wr_addr_next = sweep_addr;
            wr_data_next = BLANK;
            if (sweep_done) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   assign in_ready = (state_reg == IDLE);
   assign busy     = (state_reg != IDLE);
   assign wr_en    = wr_en_reg;
   assign wr_addr  = wr_addr_reg;
   assign wr_data  = wr_data_reg;
   assign cur_col  = col_reg;
   assign cur_row  = row_reg;

endmodule

// File: tb/tb_text_writer.sv
// Directed self-checking bench for text_writer at default geometry.
module tb_text_writer;

   logic        px_clk;
   logic        rst;
   logic        in_valid;
   logic [7:0]  in_data;
   logic        in_ready;
   logic        wr_en;
   logic [12:0] wr_addr;
   logic [7:0]  wr_data;
   logic [6:0]  cur_col;
   logic [5:0]  cur_row;
   logic        busy;

   int total = 0;
   int bad   = 0;

   text_writer dut (
      .px_clk   (px_clk),
      .rst      (rst),
      .in_valid (in_valid),
      .in_data  (in_data),
      .in_ready (in_ready),
      .wr_en    (wr_en),
      .wr_addr  (wr_addr),
      .wr_data  (wr_data),
      .cur_col  (cur_col),
      .cur_row  (cur_row),
      .busy     (busy)
   );

   initial px_clk = 1'b0;
   always #5 px_clk = ~px_clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   task automatic check_write(input string tag, input int addr, input int data);
      check({tag, "_en"},   32'(wr_en),   1);
      check({tag, "_addr"}, 32'(wr_addr), addr);
      check({tag, "_data"}, 32'(wr_data), data);
   endtask

   task automatic check_cursor(input string tag, input int col, input int row);
      check({tag, "_col"}, 32'(cur_col), col);
      check({tag, "_row"}, 32'(cur_row), row);
   endtask

   // Collects sweep writes until in_ready returns; expects n BLANK writes from base.
   task automatic collect_sweep(input int base, input int n, input string tag);
      int k = 0;
      int cyc = 0;
      do begin
         @(negedge px_clk);
         cyc++;
         if (wr_en) begin
            check({tag, "_addr"}, 32'(wr_addr), base + k);
            check({tag, "_data"}, 32'(wr_data), 'h20);
            k++;
         end
      end while (!in_ready && cyc < n + 20);
      check({tag, "_count"}, k, n);
      check({tag, "_ready"}, 32'(in_ready), 1);
      check({tag, "_busy"},  32'(busy), 0);
      $display("sweep %s: base=%0d writes=%0d", tag, base, k);
   endtask

   // Presents one byte at a negedge, returns at the negedge where its write is visible.
   task automatic send_byte(input logic [7:0] b);
      int c = 0;
      while (!in_ready && c < 10000) begin
         @(negedge px_clk);
         c++;
      end
      check("ready_wait", 32'(in_ready), 1);
      in_valid = 1'b1;
      in_data  = b;
      @(negedge px_clk);
      in_valid = 1'b0;
      $display("byte %02h: wr_en=%0d addr=%0d data=%02h col=%0d row=%0d ready=%0d",
               b, wr_en, wr_addr, wr_data, cur_col, cur_row, in_ready);
   endtask

   initial begin
      rst      = 1'b1;
      in_valid = 1'b0;
      in_data  = 8'h00;

      // Reset values
      @(negedge px_clk);
      check("rst_ready", 32'(in_ready), 0);
      check("rst_wr_en", 32'(wr_en), 0);
      check("rst_addr",  32'(wr_addr), 0);
      check("rst_data",  32'(wr_data), 'h20);
      check_cursor("rst", 0, 0);
      check("rst_busy",  32'(busy), 1);

      // Power-up screen clear
      @(negedge px_clk);
      rst = 1'b0;
      collect_sweep(0, 4800, "init");
      @(negedge px_clk);
      check("init_nodup", 32'(wr_en), 0);

      // 'H','i' back to back
      in_valid = 1'b1;
      in_data  = 8'h48;
      @(negedge px_clk);
      check_write("H", 0, 'h48);
      in_data = 8'h69;
      @(negedge px_clk);
      in_valid = 1'b0;
      check_write("i", 1, 'h69);
      check_cursor("hi", 2, 0);
      $display("byte 48,69: back-to-back writes checked col=%0d row=%0d", cur_col, cur_row);

      // DEL is ignored
      send_byte(8'h7F);
      check("del_nowrite", 32'(wr_en), 0);
      check_cursor("del", 2, 0);

      // CR back to column 0
      send_byte(8'h0D);
      check("cr_nowrite", 32'(wr_en), 0);
      check_cursor("cr", 0, 0);

      // Full line of 'A' wraps into row 1 and clears it
      for (int i = 0; i < 80; i++) begin
         send_byte(8'h41);
         check_write("A", i, 'h41);
      end
      check_cursor("wrap", 0, 1);
      check("wrap_ready", 32'(in_ready), 0);
      check("wrap_busy",  32'(busy), 1);
      collect_sweep(80, 80, "wrap");

      // Walk down to the last row with LF
      for (int r = 2; r < 60; r++) begin
         send_byte(8'h0A);
         check("lf_nowrite", 32'(wr_en), 0);
         check_cursor("lf", 0, r);
         collect_sweep(r * 80, 80, "lf");
      end
      for (int i = 0; i < 5; i++) begin
         send_byte(8'h62);
         check_write("b", 4720 + i, 'h62);
      end
      check_cursor("row59", 5, 59);

      // LF on last row wraps to row 0 keeping column
      send_byte(8'h0A);
      check("lfw_nowrite", 32'(wr_en), 0);
      check_cursor("lfw", 5, 0);
      collect_sweep(0, 80, "lf_wrap");
      send_byte(8'h5A);
      check_write("Z", 5, 'h5A);
      check_cursor("Z", 6, 0);

      // Move to (0,3)
      send_byte(8'h0D);
      for (int r = 1; r < 4; r++) begin
         send_byte(8'h0A);
         collect_sweep(r * 80, 80, "lf3");
      end
      check_cursor("row3", 0, 3);

      // BS at column 0 does nothing
      send_byte(8'h08);
      check("bs0_nowrite", 32'(wr_en), 0);
      check_cursor("bs0", 0, 3);

      // 'x','y',BS
      send_byte(8'h78);
      check_write("x", 240, 'h78);
      send_byte(8'h79);
      check_write("y", 241, 'h79);
      send_byte(8'h08);
      check_write("bs", 241, 'h20);
      check_cursor("bs", 1, 3);

      // FF homes the cursor and starts a screen clear
      send_byte(8'h0C);
      check("ff_nowrite", 32'(wr_en), 0);
      check_cursor("ff", 0, 0);
      check("ff_ready", 32'(in_ready), 0);
      check("ff_busy",  32'(busy), 1);

      // Reset in the middle of the screen clear
      begin
         int c = 0;
         while (!(wr_en && wr_addr == 13'd2000) && c < 3000) begin
            @(negedge px_clk);
            c++;
         end
      end
      check("mid_en",   32'(wr_en), 1);
      check("mid_addr", 32'(wr_addr), 2000);
      #2;
      rst = 1'b1;
      #1;
      check("mid_rst_wr_en", 32'(wr_en), 0);
      in_valid = 1'b1;
      in_data  = 8'h51;
      @(negedge px_clk);
      @(negedge px_clk);
      check("mid_rst_ready", 32'(in_ready), 0);
      check("mid_rst_busy",  32'(busy), 1);
      check("mid_rst_en2",   32'(wr_en), 0);
      rst = 1'b0;
      collect_sweep(0, 4800, "rst_mid");
      @(negedge px_clk);
      in_valid = 1'b0;
      check_write("Q", 0, 'h51);
      check_cursor("Q", 1, 0);
      $display("byte 51: held through reset, wr_en=%0d addr=%0d data=%02h", wr_en, wr_addr, wr_data);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/text_writer.md
Name: text_writer

Overview:
- Upstream feeder for the character RAM write port, which the VGA text pipeline currently leaves disabled.
- Accepts a byte stream over a valid/ready handshake and interprets it as terminal text.
- Keeps a cursor, and writes glyph codes into the COLS x ROWS character RAM in row-major order.
- Handles CR, LF, BS and FF, auto-wraps at end of line, and blanks lines and screen with a sweep sequencer.

Parameters:
- COLS, 80, characters per row (640/8).
- ROWS, 60, character rows (480/8).
- ADDR_W, 13, RAM address width; must satisfy 2^ADDR_W >= COLS*ROWS.
- BLANK, 8'h20, code written when clearing cells.

Ports:
- px_clk  in  1  pixel clock; same clock as the RAM write port.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  source presents a byte.
- in_data  in  8  character or control code.
- in_ready  out  1  block can accept a byte this cycle.
- wr_en  out  1  RAM write strobe, registered.
- wr_addr  out  ADDR_W  RAM write address, registered; equals row*COLS+col.
- wr_data  out  8  RAM write data, registered.
- cur_col  out  7  cursor column, 0..COLS-1.
- cur_row  out  6  cursor row, 0..ROWS-1.
- busy  out  1  a sweep (screen or line clear) is in progress.

Behaviour:
- Clock and reset: single clock px_clk; asynchronous, active-high reset rst.
- Reset values: in_ready=0, wr_en=0, wr_addr=0, wr_data=BLANK, cur_col=0, cur_row=0, busy=1, state=CLR_SCREEN, sweep counter=0.
- Reset mid-operation: aborts any sweep or pending write; no partial write is issued after rst rises.
- States:
  - CLR_SCREEN: writes BLANK to addresses 0..COLS*ROWS-1, one per cycle (4800 cycles at defaults); then IDLE.
  - IDLE: in_ready=1 and busy=0.
  - CLR_LINE: writes BLANK to row_base..row_base+COLS-1, one per cycle; then IDLE.
- in_ready is 1 only in IDLE.
- Handshake: a byte is accepted when in_valid && in_ready. The source must hold in_data while in_valid=1 and in_ready=0.
- Latency: for an accepted byte, any resulting write appears on wr_en/wr_addr/wr_data exactly 1 cycle later. wr_en is 1 for exactly that one cycle; otherwise 0 except during sweeps.
- Address: row_base (row*COLS) is a register, +COLS per row advance and reset to 0 on wrap. No multiplier; wr_addr = row_base + col.
- Printable codes (0x20..0x7E and 0x80..0xFF):
  - Write the code at the cursor, then col+1.
  - If col was COLS-1: col=0 and row advances (see row advance).
- CR (0x0D): col=0, no write.
- LF (0x0A): row advances, col unchanged.
- BS (0x08): if col>0, col-1 and write BLANK at the new position. At col=0: no change, no write.
- FF (0x0C): cursor to (0,0), row_base=0, enter CLR_SCREEN.
- Other codes (0x00..0x1F not listed above, and 0x7F): accepted and ignored; no write, cursor unchanged.
- Row advance:
  - row+1, or row=0 with row_base=0 when row was ROWS-1 (wrap, no scroll).
  - Then enter CLR_LINE for the new row. in_ready drops the cycle after acceptance.
  - For a printable at the last column, the glyph write occurs before the first sweep write.
- Sweep write data: BLANK.
- Cursor outputs update in the cycle the write is issued, so they match the post-operation cursor.

Decomposition:
- Shared package text_pkg holds:
  - COLS, ROWS and ADDR_W defaults;
  - code constants CH_BS=8'h08, CH_LF=8'h0A, CH_FF=8'h0C, CH_CR=8'h0D, CH_DEL=8'h7F, BLANK=8'h20;
  - state encoding for IDLE, CLR_LINE, CLR_SCREEN.
- One sub-module is natural: cell_sweep.
  - Inputs: start, base, count.
  - Outputs: addr, active, done.
  - Reused for both screen clear and line clear.

Test Plan:
- Release rst: exactly 4800 writes of 8'h20 to addresses 0..4799, one per cycle. Then in_ready=1 and busy=0; no write is duplicated.
- After init, send 'H','i' back-to-back: writes (0,8'h48) then (1,8'h69), each 1 cycle after acceptance. Then cur_col=2, cur_row=0.
- Send 80 × 'A' from (0,0): writes at 0..79. The 80th sets cur_row=1, cur_col=0. Then 80 BLANK writes to 80..159 with in_ready=0, after which in_ready=1.
- Cursor at (5,59): LF → cur_row=0, cur_col=5, 80 BLANK writes at 0..79. Then 'Z' → write (5,8'h5A).
- Cursor at (0,3): BS → no write, cursor unchanged. Then 'x','y',BS → last write is BLANK at 241 and cur_col=1.
- Assert rst mid-CLR_SCREEN (address ~2000):
  - wr_en goes 0 asynchronously.
  - After release, the sweep restarts at 0 and completes 4800 writes.
  - in_valid held high throughout is accepted only after the sweep completes.
